// File: rtl/genbus_pkg.sv
// Shared types for the genbus master sequencer: bus widths, FSM state type
// and the one-hot select decoder used in DECODE.
package genbus_pkg;

  localparam int ADR_W      = 8;
  localparam int DAT_W      = 8;
  localparam int MAX_SLAVES = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } onehot_t;

  // valid only when exactly one select bit is set; narrower selects are zero-extended
  function automatic onehot_t onehot_idx(input logic [MAX_SLAVES-1:0] sel);
    onehot_t r;
    int      n;
    r.valid = 1'b0;
    r.idx   = '0;
    n       = 0;
    for (int i = 0; i < MAX_SLAVES; i++) begin
      if (sel[i]) begin
        n     = n + 1;
        r.idx = IDX_W'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/genbus_tmo.sv
// Access timeout counter: cleared outside ACCESS, counts ACCESS cycles from 1,
// flags expiry when the count reaches TMO.
module genbus_tmo #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'(TMO));

endmodule

// File: rtl/genbus_ctrl.sv
// Master-side genbus sequencer: IDLE -> DECODE -> ACCESS -> DONE.
// Optional 8-bit saturating error counter under GENBUS_CTRL_ERRCNT_EN.
module genbus_ctrl
  import genbus_pkg::*;
#(
  parameter int NSLAVES = 2,
  parameter int TMO     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [ADR_W-1:0]         m_adr,
  input  logic [DAT_W-1:0]         m_wdat,
  output logic                     m_gnt,
  output logic                     m_rdy,
  output logic [DAT_W-1:0]         m_rdat,
  output logic                     m_err,
  output logic [ADR_W*NSLAVES-1:0] s_adr,
  input  logic [NSLAVES-1:0]       s_sel,
  output logic [NSLAVES-1:0]       s_req,
  output logic                     s_we,
  output logic [DAT_W-1:0]         s_wdat,
  input  logic [DAT_W*NSLAVES-1:0] s_rdat,
  input  logic [NSLAVES-1:0]       s_ack
`ifdef GENBUS_CTRL_ERRCNT_EN
  ,
  output logic [7:0]               err_cnt
`endif
);

  localparam int KW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  ctrl_state_t             state_q, state_d;
  logic [ADR_W-1:0]        adr_q, adr_d;
  logic                    we_q, we_d;
  logic [DAT_W-1:0]        wdat_q, wdat_d;
  logic [DAT_W-1:0]        rdat_q, rdat_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NSLAVES-1:0]      req_q, req_d;
  logic                    rdy_q, rdy_d;
  logic                    err_q, err_d;
  logic [MAX_SLAVES-1:0]   sel_ext_s;
  onehot_t                 oh_s;
  logic                    ack_s;
  logic [DAT_W-1:0]        lane_rdat_s;
  logic                    tmo_en_s;
  logic                    tmo_exp_s;

  // Only the selected lane's ack and read data are visible to the FSM
  always_comb begin
    ack_s       = 1'b0;
    lane_rdat_s = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      ack_s       = (k_q == KW'(i)) ? s_ack[i] : ack_s;
      lane_rdat_s = (k_q == KW'(i)) ? s_rdat[i*DAT_W +: DAT_W] : lane_rdat_s;
    end
  end

  always_comb begin
    sel_ext_s              = '0;
    sel_ext_s[NSLAVES-1:0] = s_sel;
    oh_s                   = onehot_idx(sel_ext_s);
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    k_d     = k_q;
    req_d   = '0;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          adr_d   = m_adr;
          we_d    = m_we;
          wdat_d  = m_wdat;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (oh_s.valid) begin
          k_d     = oh_s.idx[KW-1:0];
          state_d = ACCESS;
          for (int i = 0; i < NSLAVES; i++) begin
            req_d[i] = (oh_s.idx == IDX_W'(i));
          end
        end else begin
          state_d = DONE;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      ACCESS: begin
        // an ack in the expiry cycle still completes without error
        if (ack_s) begin
          rdat_d  = we_q ? rdat_q : lane_rdat_s;
          state_d = DONE;
          rdy_d   = 1'b1;
        end else if (tmo_exp_s) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          req_d   = req_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tmo_en_s = (state_d == ACCESS);

  genbus_tmo #(.TMO(TMO)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (~tmo_en_s),
    .en_i      (tmo_en_s),
    .expired_o (tmo_exp_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      k_q     <= '0;
      req_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      k_q     <= k_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

`ifdef GENBUS_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (rdy_d && err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  // grant is combinational so the capture cycle itself carries the pulse
  assign m_gnt  = (state_q == IDLE) & m_req;
  assign m_rdy  = rdy_q;
  assign m_err  = err_q;
  assign m_rdat = rdat_q;
  assign s_adr  = {NSLAVES{adr_q}};
  assign s_req  = req_q;
  assign s_we   = we_q;
  assign s_wdat = wdat_q;

endmodule

// File: doc/genbus_ctrl.md
Name: genbus_ctrl

Overview:
- Master-side bus sequencer that sits directly upstream of the genbus address decoder.
- Accepts single read/write requests from the CPU core and broadcasts the registered address onto every slave address lane.
- Uses the decoder's per-slave select to issue a request to exactly one slave, then waits for that slave's acknowledge.
- Returns read data, or a bus error on no-select, multi-select or timeout.

Parameters:
- NSLAVES, 2, number of slaves; slave index i runs 1..NSLAVES, bit/lane i-1 in flat vectors.
- TMO, 15, maximum cycles in ACCESS before timeout error; legal range 1..255.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- m_req  input  1  CPU request valid.
- m_we  input  1  1 = write, 0 = read.
- m_adr  input  8  CPU address.
- m_wdat  input  8  write data.
- m_gnt  output  1  one-cycle pulse: request captured.
- m_rdy  output  1  one-cycle pulse: transaction complete.
- m_rdat  output  8  read data, valid while m_rdy=1.
- m_err  output  1  bus error, valid while m_rdy=1.
- s_adr  output  8*NSLAVES  per-slave address lanes, all equal to the latched address.
- s_sel  input  NSLAVES  per-slave select from the decoder (combinational on s_adr).
- s_req  output  NSLAVES  per-slave request, at most one bit high.
- s_we  output  1  latched write enable.
- s_wdat  output  8  latched write data.
- s_rdat  input  8*NSLAVES  per-slave read data.
- s_ack  input  NSLAVES  per-slave acknowledge.

Behaviour:
- Reset values: state IDLE; s_adr, s_wdat and m_rdat 0; s_we, s_req, m_gnt, m_rdy and m_err 0; timeout counter 0.
- IDLE:
  - On m_req=1, latch m_adr, m_we and m_wdat.
  - Pulse m_gnt for one cycle.
  - Go to DECODE.
  - m_req is ignored in every other state; the CPU holds or drops it, and it is not re-sampled until IDLE.
- DECODE (1 cycle): s_sel is valid because s_adr is now stable. Then:
  - exactly one bit set: record index k, go to ACCESS.
  - zero bits set: go to DONE with error.
  - more than one bit set: go to DONE with error.
- ACCESS:
  - Drive s_req[k]=1; the counter increments every cycle starting at 1.
  - s_ack[k]=1: capture s_rdat lane k into m_rdat (reads only; writes leave m_rdat unchanged); go to DONE, no error.
  - Counter reaches TMO without an ack: go to DONE with error.
  - Ack in the same cycle as the counter reaching TMO: the ack wins, no error.
  - s_ack on a lane other than k is ignored.
- DONE (1 cycle): m_rdy=1, m_err as determined; s_req=0; counter cleared; return to IDLE.
- Latency:
  - Read with same-cycle ack: m_gnt at cycle 0, s_req high in cycle 2, m_rdy in cycle 3.
  - Minimum request-to-m_rdy: 3 cycles.
  - Back-to-back: a new m_gnt is possible in the cycle after DONE.
- s_adr, s_we and s_wdat hold their latched value until the next grant; they do not return to 0.
- Reset asserted mid-operation: immediate return to IDLE, s_req dropped asynchronously, no m_rdy generated.

Optional Feature:
- Macro: GENBUS_CTRL_ERRCNT_EN.
- Defined:
  - Adds output err_cnt (8 bits), reset to 0.
  - Increments in every DONE cycle with m_err=1.
  - Saturates at 255.
- Undefined: no err_cnt port and no counter logic; all other behaviour identical.

Decomposition:
- Package genbus_pkg:
  - ADR_W=8, DAT_W=8.
  - Enum ctrl_state_t {IDLE, DECODE, ACCESS, DONE}.
  - Function onehot_idx returning the index and a valid flag for an NSLAVES-wide select (valid only if exactly one bit is set).
- One sub-module, genbus_tmo:
  - Clear/enable timeout counter, TMO parameter.
  - Outputs an expired flag.
  - Same clk/rst.

Test Plan:
- Reset mid-ACCESS: assert rst while s_req[0]=1 -> s_req=0 and state IDLE immediately; no m_rdy pulse after release.
- Read from slave 1:
  - Stimulus: m_adr=0x05, m_we=0, decoder selects lane 0, s_ack[0] in first ACCESS cycle, s_rdat lane0=0xA5.
  - Response: m_gnt at cycle 0, s_req=2'b01 at cycle 2, m_rdy=1, m_rdat=0xA5, m_err=0 at cycle 3.
- Write to slave 2:
  - Stimulus: m_adr=0x17, m_wdat=0x3C, m_we=1, s_ack[1] after 4 cycles.
  - Response: s_adr lanes both 0x17, s_we=1, s_wdat=0x3C, s_req=2'b10 for 4 cycles; m_rdy with m_err=0; m_rdat unchanged.
- Unmapped address:
  - Stimulus: m_adr=0x40, s_sel=0.
  - Response: no s_req asserted; m_rdy=1, m_err=1 at cycle 2; err_cnt=1 when GENBUS_CTRL_ERRCNT_EN is defined.
- Timeout:
  - Stimulus: TMO=15, selected slave never acks.
  - Response: s_req high for exactly 15 cycles, then m_rdy=1, m_err=1.
  - Repeat with the ack on cycle 15 -> m_err=0.
- Back-to-back with ignored request:
  - Stimulus: two reads with m_req held high continuously.
  - Response: second m_gnt one cycle after the first m_rdy; m_req is not re-sampled during DECODE/ACCESS/DONE.
